sign_mag_to_twos_stream: RTL and testbench

Streaming decoder that converts N-bit sign-magnitude words, as produced by the team's sign-magnitude adder datapath, back into N-bit two's-complement words for downstream arithmetic.
- Input and output both use valid/ready handshakes.
- A 2-entry output buffer decouples the two sides.
- Negative zero is flagged per word and counted in a saturating statistics counter.
- Sits between the sign-magnitude arithmetic cluster and the two's-complement consumers.

---
 rtl/sign_mag_to_twos_stream.sv | 86 ++++++++
 tb/tb_sign_mag_to_twos_stream.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sign_mag_to_twos_stream.sv
// rtl/sign_mag_to_twos_stream.sv - sign-magnitude to two's-complement stream decoder
// Converts at write time into a 2-entry buffer; negative zeros are flagged and counted.
module sign_mag_to_twos_stream #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_negz,
  output logic [CW-1:0] negz_cnt,
  input  logic          cnt_clr
);

  logic [N-1:0] buf_data [2];
  logic         buf_negz [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  logic         sign;
  logic [N-1:0] pos_word;
  logic [N-1:0] conv_data;
  logic         conv_negz;
  logic         push;
  logic         pop;

  assign sign     = in_data[N-1];
  assign pos_word = {1'b0, in_data[N-2:0]};

  // Negating a zero magnitude also yields zero, so negative zero needs no special data path.
  assign conv_data = sign ? (~pos_word + {{(N-1){1'b0}}, 1'b1}) : pos_word;
  assign conv_negz = sign & (in_data[N-2:0] == '0);

  // in_ready depends only on registered count, never on out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data = out_valid ? buf_data[rd_ptr] : '0;
  assign out_negz = out_valid ? buf_negz[rd_ptr] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_negz[0] <= 1'b0;
      buf_negz[1] <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= conv_data;
        buf_negz[wr_ptr] <= conv_negz;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Counted at acceptance so statistics do not depend on consumer pacing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      negz_cnt <= '0;
    end else if (cnt_clr) begin
      negz_cnt <= '0;
    end else if (push && conv_negz && !(&negz_cnt)) begin
      negz_cnt <= negz_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_sign_mag_to_twos_stream.sv
// tb/tb_sign_mag_to_twos_stream.sv - self-checking bench for sign_mag_to_twos_stream
module tb_sign_mag_to_twos_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_negz;
  logic [1:0] negz_cnt;
  logic       cnt_clr;

  int checks = 0;
  int failures = 0;

  sign_mag_to_twos_stream #(.N(4), .CW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_negz(out_negz), .negz_cnt(negz_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [3:0] id;
    logic       ordy;
    logic       clr;
    logic       ev;
    logic       er;
    logic [3:0] ed;
    logic       en;
    logic [1:0] ec;
  } vec_t;

  typedef struct {
    logic [3:0] d;
    logic       z;
  } ent_t;

  vec_t tbl[20];
  ent_t mq[$];
  int   mcnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic er,
                         input logic [3:0] ed, input logic en, input logic [1:0] ec);
    chk({tag, ".out_valid"}, int'(out_valid), int'(ev));
    chk({tag, ".in_ready"},  int'(in_ready),  int'(er));
    chk({tag, ".out_data"},  int'(out_data),  int'(ed));
    chk({tag, ".out_negz"},  int'(out_negz),  int'(en));
    chk({tag, ".negz_cnt"},  int'(negz_cnt),  int'(ec));
  endtask

  // Reference conversion: signed integer value of the word, truncated to 4 bits.
  function automatic ent_t ref_conv(input logic [3:0] w);
    ent_t e;
    int   m;
    int   v;
    m   = int'(w[2:0]);
    v   = w[3] ? -m : m;
    e.d = v[3:0];
    e.z = w[3] && (m == 0);
    return e;
  endfunction

  // Called at posedge+1: compare model to outputs, then advance one clock.
  task automatic model_cycle(input logic iv, input logic [3:0] id, input logic ordy, input logic clr);
    logic do_push;
    logic do_pop;
    ent_t e;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    e = '{d: 4'd0, z: 1'b0};
    if (mq.size() != 0) e = mq[0];
    chk_all("rand", mq.size() != 0, mq.size() < 2, e.d, e.z, mcnt[1:0]);
    do_push = iv && (mq.size() < 2);
    do_pop  = ordy && (mq.size() != 0);
    e = ref_conv(id);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(e);
    if (clr) mcnt = 0;
    else if (do_push && e.z && mcnt < 3) mcnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {in_valid, in_data, out_ready, cnt_clr} -> outputs after that edge
    tbl[0]  = '{1'b1, 4'b0101, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0101, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 4'b1101, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b0, 2'd0};
    tbl[2]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1001, 1'b0, 2'd0};
    tbl[3]  = '{1'b1, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd1};
    tbl[4]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd1};
    tbl[5]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1};
    tbl[6]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 2'd1};
    tbl[7]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd1};
    tbl[8]  = '{1'b1, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd1};
    tbl[9]  = '{1'b1, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 2'd1};
    tbl[10] = '{1'b1, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0011, 1'b0, 2'd1};
    tbl[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1};
    tbl[12] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[13] = '{1'b1, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd1};
    tbl[14] = '{1'b1, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd2};
    tbl[15] = '{1'b1, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd3};
    tbl[16] = '{1'b1, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd3};
    tbl[17] = '{1'b1, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd3};
    tbl[18] = '{1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[19] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0; cnt_clr = 1'b0;
    #1;
    chk_all("reset", 1'b0, 1'b1, 4'd0, 1'b0, 2'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy; cnt_clr = tbl[i].clr;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].er, tbl[i].ed, tbl[i].en, tbl[i].ec);
    end

    // Async reset with two buffered words and a nonzero counter.
    in_valid = 1'b1; in_data = 4'b0011; out_ready = 1'b0; cnt_clr = 1'b0;
    @(posedge clk); #1;
    in_data = 4'b1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_all("pre_rst", 1'b1, 1'b0, 4'b0011, 1'b0, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b1, 4'd0, 1'b0, 2'd0);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 4'b0110;
    @(posedge clk); #1;
    chk_all("post_rst", 1'b1, 1'b1, 4'b0110, 1'b0, 2'd0);

    // Randomized phase against the queue model, starting from a fresh reset.
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    mq.delete();
    mcnt = 0;
    for (int i = 0; i < 600; i++) begin
      model_cycle(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
